pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Multi-channel, width-parametrised PWM generator that replaces the single fixed 8-bit channel.
- CHANNELS outputs share one period counter.
- The period is programmable, and so is the mode: edge-aligned (sawtooth) or center-aligned (triangle).
- Duty, period and mode are double-buffered, so updates take effect only at a period boundary and never glitch a running cycle.
- Sits between the waveform/sample logic and the output pads.

Parameters:
WIDTH, 8, bit width of counter, period and each duty value
CHANNELS, 4, number of independent PWM outputs

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
enable  in  1  run counter; 0 = hold counter at 0, outputs inactive
load  in  1  one-cycle strobe: capture duty, period, center into shadow registers
duty  in  CHANNELS*WIDTH  channel i duty at bits [i*WIDTH +: WIDTH]
period  in  WIDTH  top count value P
center  in  1  mode select: 0 = edge-aligned, 1 = center-aligned
invert  in  CHANNELS  per-channel output polarity, live (not shadowed)
pwm  out  CHANNELS  registered PWM outputs
cycle_start  out  1  registered one-cycle pulse marking counter value 0

Behaviour:
- Registers:
  - cnt[WIDTH], dir (up/down).
  - Shadow set: pend_duty[CHANNELS], pend_period, pend_center.
  - Active set: act_duty, act_period, act_center.
  - pwm and cycle_start.
- Reset (rst high at clk edge; overrides all other inputs):
  - cnt=0, dir=up, pwm=0, cycle_start=0.
  - All duties 0, both periods = 2^WIDTH-1, both center = 0.
- load=1: pending set <= duty/period/center inputs on that edge. Active set is unaffected unless a boundary or disabled condition applies.
- Edge mode counter:
  - Counts 0,1,...,P, then back to 0.
  - Period length is P+1 cycles.
- Center mode counter:
  - Counts up 0..P, then down P-1..1, then back to 0.
  - Period length is 2P cycles; dir flips at P and at 1.
- P=0: cnt stays 0 and every cycle is a boundary, in both modes.
- Boundary: the edge at which cnt transitions to 0 (or stays 0 when P=0) while enable=1.
  - At a boundary, active set <= pending set and dir <= up.
  - The compare at cnt=0 already uses the new active values.
- load and boundary on the same edge: pending takes the new inputs; active takes the old pending contents. The new load is applied at the following boundary.
- enable=0:
  - cnt <= 0, dir <= up.
  - Active set <= pending set every edge, so a load becomes visible on the edge after it.
  - pwm[i] <= invert[i]; cycle_start <= 0.
- enable 0->1: the first counted cycle is cnt=0 and cycle_start pulses for it.
- Output, when enabled: pwm[i] <= (cnt < act_duty[i]) XOR invert[i].
  - Latency is one clock from the cnt value to the pin.
  - cycle_start <= (cnt==0), aligned with pwm.
- Duty arithmetic: unsigned WIDTH-bit compare, no overflow.
  - Edge mode high time = min(D, P+1) cycles per period.
  - Center mode high time:
    - D=0: 0 cycles.
    - 1<=D<=P: 2D-1 cycles, centred on cnt=0.
    - D>P: 2P cycles (always high).
  - D=0 gives constant low and D>P gives constant high, both before invert.
- invert acts immediately (next edge) and is not shadowed.
- Reset asserted mid-period: on that edge every register takes its reset value. No partial period completes afterwards.

Test Plan:
1. WIDTH=8, CHANNELS=4. Reset, load period=9, center=0, duty ch0..3={0,3,9,10}, enable=1 -> cycle_start every 10 cycles; pwm high 0/3/9/10 of every 10 cycles. ch0 is constant 0 and ch3 is constant 1.
2. Same setup, invert=4'b0010 mid-run -> pwm[1] becomes low 3 / high 7 starting on the next edge, without waiting for a boundary. Other channels are unchanged.
3. Load center=1, period=4, ch0 duty=2 -> after the boundary, counter sequence is 0,1,2,3,4,3,2,1 repeating. pwm[0] is high for 3 cycles (cnt 0,1 and trailing 1), and cycle_start pulses every 8 cycles.
4. Edge mode, period=9, ch0 duty 3; load duty=7 at cnt=5 -> the current period still shows 3 high cycles and the next shows 7. Repeat with load asserted on the boundary edge -> the change is delayed by one further period.
5. Drop enable at cnt=6 -> next edge: pwm = invert, cycle_start=0, cnt=0. Raise enable -> cycle_start pulses on the first cycle and a full period follows.
6. Assert rst for one cycle at cnt=6 while running center mode -> next edge: pwm=0, cycle_start=0, cnt=0, duties 0, period 255, edge mode. With enable=1 and no load, cycle_start then repeats every 256 cycles.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one period counter.
//   Counter runs edge-aligned (0..P, wrap) or center-aligned (0..P..1, wrap).
//   Duty/period/mode are double-buffered: load captures them into a pending
//   set, which moves to the active set at each period boundary (or on every
//   edge while disabled). invert is live and not buffered.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          run counter; 0 holds counter at 0 and drives pwm = invert
//   load            strobe capturing duty/period/center into the pending set
//   duty            per-channel duty, channel i at [i*WIDTH +: WIDTH]
//   period          top count value P
//   center          0 = edge-aligned, 1 = center-aligned
//   invert          per-channel output polarity
//   pwm             registered PWM outputs
//   cycle_start     registered pulse for the counter-at-0 cycle

// Per-channel duty buffering, compare and output register.
module pwm_multi_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             swap_i,
    input  logic             run_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             invert_i,
    output logic             pwm_o
);
    logic [WIDTH-1:0] pend_q, act_q;
    logic             pwm_q, pwm_d;

    // Compare uses the active duty that is current for this cnt value.
    always_comb begin
        pwm_d = invert_i;
        if (run_i) pwm_d = (cnt_i < act_q) ^ invert_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            act_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            if (load_i) pend_q <= duty_i;
            // swap sees the pre-load pending value, so a load coinciding
            // with a boundary lands one period later.
            if (swap_i) act_q <= pend_q;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;
endmodule

module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center,
    input  logic [CHANNELS-1:0]       invert,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      cycle_start
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_up_q, dir_up_d;
    logic [WIDTH-1:0] pend_period_q, act_period_q;
    logic             pend_center_q, act_center_q;
    logic             cs_q, cs_d;
    logic             boundary;
    logic             swap;

    always_comb begin
        cnt_d    = cnt_q;
        dir_up_d = dir_up_q;
        if (!enable) begin
            cnt_d    = '0;
            dir_up_d = 1'b1;
        end else if (!act_center_q) begin
            cnt_d = (cnt_q >= act_period_q) ? '0 : cnt_q + WIDTH'(1);
        end else if (dir_up_q) begin
            if (cnt_q >= act_period_q) begin
                // Turn around at the top; P=0 and P=1 fall straight to 0.
                cnt_d    = (act_period_q == '0) ? '0 : act_period_q - WIDTH'(1);
                dir_up_d = 1'b0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = (cnt_q <= WIDTH'(1)) ? '0 : cnt_q - WIDTH'(1);
        end
        boundary = enable && (cnt_d == '0);
        if (boundary) dir_up_d = 1'b1;
        swap = !enable || boundary;
        cs_d = enable && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            dir_up_q      <= 1'b1;
            pend_period_q <= '1;
            act_period_q  <= '1;
            pend_center_q <= 1'b0;
            act_center_q  <= 1'b0;
            cs_q          <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_up_q <= dir_up_d;
            cs_q     <= cs_d;
            if (load) begin
                pend_period_q <= period;
                pend_center_q <= center;
            end
            if (swap) begin
                act_period_q <= pend_period_q;
                act_center_q <= pend_center_q;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_multi_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load),
            .swap_i   (swap),
            .run_i    (enable),
            .cnt_i    (cnt_q),
            .duty_i   (duty[i*WIDTH +: WIDTH]),
            .invert_i (invert[i]),
            .pwm_o    (pwm[i])
        );
    end

    assign cycle_start = cs_q;
endmodule

// File: tb/tb_pwm_multi.sv
module tb_pwm_multi;
    localparam int W  = 8;
    localparam int CH = 4;

    logic              clk = 1'b0;
    logic              rst, enable, load, center;
    logic [CH*W-1:0]   duty;
    logic [W-1:0]      period;
    logic [CH-1:0]     invert;
    logic [CH-1:0]     pwm;
    logic              cycle_start;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .duty(duty),
        .period(period), .center(center), .invert(invert),
        .pwm(pwm), .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] pwm;
        logic          cs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   hi_cnt[CH];
    int   cs_cnt;

    // Reference model: position within the period as a phase index; the
    // counter value is derived from the phase and the mode.
    int        m_phase;
    logic [W-1:0] m_pd[CH], m_ad[CH];
    logic [W-1:0] m_pp, m_ap;
    logic         m_pc, m_ac;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int m_cnt();
        int p = int'(m_ap);
        if (m_ac && m_phase > p) return 2*p - m_phase;
        return m_phase;
    endfunction

    task automatic m_copy();
        for (int i = 0; i < CH; i++) m_ad[i] = m_pd[i];
        m_ap = m_pp;
        m_ac = m_pc;
    endtask

    // Evaluate one edge of the model with the inputs currently driven and
    // queue the outputs the DUT must show after that edge.
    task automatic model_edge();
        exp_t e;
        int   c, p, len;
        e = '0;
        if (rst) begin
            m_phase = 0;
            for (int i = 0; i < CH; i++) begin m_pd[i] = '0; m_ad[i] = '0; end
            m_pp = '1; m_ap = '1; m_pc = 1'b0; m_ac = 1'b0;
        end else begin
            if (enable) begin
                c = m_cnt();
                for (int i = 0; i < CH; i++) e.pwm[i] = (c < int'(m_ad[i])) ^ invert[i];
                e.cs = (c == 0);
                p   = int'(m_ap);
                len = (p == 0) ? 1 : (m_ac ? 2*p : p + 1);
                m_phase++;
                if (m_phase >= len) begin
                    m_phase = 0;
                    m_copy();
                end
            end else begin
                e.pwm   = invert;
                e.cs    = 1'b0;
                m_phase = 0;
                m_copy();
            end
            if (load) begin
                for (int i = 0; i < CH; i++) m_pd[i] = duty[i*W +: W];
                m_pp = period;
                m_pc = center;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("pwm", 32'(pwm), 32'(e.pwm));
        check("cycle_start", 32'(cycle_start), 32'(e.cs));
        for (int i = 0; i < CH; i++) hi_cnt[i] += int'(pwm[i]);
        cs_cnt += int'(cycle_start);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clr();
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        cs_cnt = 0;
    endtask

    task automatic do_load(input int d0, input int d1, input int d2, input int d3,
                           input int p, input logic c);
        duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
        period = W'(p);
        center = c;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        int b = 600;
        while (m_phase != ph && b > 0) begin tick(); b--; end
        check("wait_phase_timeout", 32'(b > 0), 32'd1);
    endtask

    initial begin
        int b;
        clr();
        rst = 1'b1; enable = 1'b0; load = 1'b0; center = 1'b0;
        duty = '0; period = '0; invert = '0;
        tick();
        check("rst_pwm", 32'(pwm), 32'd0);
        check("rst_cs", 32'(cycle_start), 32'd0);
        rst = 1'b0;

        // Edge mode P=9, duties 0/3/9/10.
        do_load(0, 3, 9, 10, 9, 1'b0);
        tick();
        enable = 1'b1;
        ticks(25);
        clr(); ticks(100);
        check("t1_hi0", hi_cnt[0], 0);
        check("t1_hi1", hi_cnt[1], 30);
        check("t1_hi2", hi_cnt[2], 90);
        check("t1_hi3", hi_cnt[3], 100);
        check("t1_cs", cs_cnt, 10);

        // Live invert on channel 1.
        invert = 4'b0010;
        tick();
        clr(); ticks(100);
        check("t2_hi0", hi_cnt[0], 0);
        check("t2_hi1", hi_cnt[1], 70);
        check("t2_hi3", hi_cnt[3], 100);
        invert = 4'b0000;
        tick();

        // Mid-period load waits for the boundary.
        do_load(3, 3, 9, 10, 9, 1'b0);
        b = 100;
        while (!(m_ad[0] == 8'd3 && m_phase == 0) && b > 0) begin tick(); b--; end
        check("t4_sync_timeout", 32'(b > 0), 32'd1);
        clr();
        ticks(5);
        do_load(7, 3, 9, 10, 9, 1'b0);
        ticks(4);
        check("t4_cur_period", hi_cnt[0], 3);
        clr(); ticks(10);
        check("t4_next_period", hi_cnt[0], 7);
        // Load on the boundary edge lands one period later.
        wait_phase(9);
        do_load(3, 3, 9, 10, 9, 1'b0);
        clr(); ticks(10);
        check("t4b_old_period", hi_cnt[0], 7);
        clr(); ticks(10);
        check("t4b_new_period", hi_cnt[0], 3);

        // Disable mid-period, then re-enable.
        invert = 4'b0101;
        wait_phase(6);
        enable = 1'b0;
        tick();
        check("t5_dis_pwm", 32'(pwm), 32'h5);
        check("t5_dis_cs", 32'(cycle_start), 32'd0);
        ticks(2);
        invert = 4'b0000;
        tick();
        enable = 1'b1;
        clr();
        tick();
        check("t5_en_cs", 32'(cycle_start), 32'd1);
        ticks(9);
        check("t5_cs_cnt", cs_cnt, 1);
        check("t5_hi0", hi_cnt[0], 3);
        check("t5_hi2", hi_cnt[2], 9);
        check("t5_hi3", hi_cnt[3], 10);

        // P=0: every cycle is a boundary, both modes.
        enable = 1'b0;
        do_load(0, 1, 0, 0, 0, 1'b0);
        tick();
        enable = 1'b1;
        clr(); ticks(10);
        check("p0e_cs", cs_cnt, 10);
        check("p0e_hi1", hi_cnt[1], 10);
        check("p0e_hi0", hi_cnt[0], 0);
        do_load(0, 1, 0, 0, 0, 1'b1);
        tick();
        clr(); ticks(10);
        check("p0c_cs", cs_cnt, 10);
        check("p0c_hi1", hi_cnt[1], 10);

        // Center mode P=4, ch0 duty 2.
        do_load(2, 0, 5, 0, 4, 1'b1);
        b = 100;
        while (!(m_ac && m_ap == 8'd4 && m_phase == 0) && b > 0) begin tick(); b--; end
        check("t3_sync_timeout", 32'(b > 0), 32'd1);
        clr(); ticks(80);
        check("t3_hi0", hi_cnt[0], 30);
        check("t3_hi2", hi_cnt[2], 80);
        check("t3_cs", cs_cnt, 10);

        // Reset mid-period while running center mode.
        do_load(2, 5, 9, 12, 9, 1'b1);
        b = 200;
        while (!(m_ac && m_ap == 8'd9 && m_phase == 6) && b > 0) begin tick(); b--; end
        check("t6_sync_timeout", 32'(b > 0), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_pwm", 32'(pwm), 32'd0);
        check("t6_rst_cs", 32'(cycle_start), 32'd0);
        clr(); ticks(512);
        check("t6_cs_256", cs_cnt, 2);
        check("t6_hi3", hi_cnt[3], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
